// File: rtl/clock_pkg.sv
// clock_pkg: seven-segment codes (active-low, bit0 = a .. bit6 = g) and modulus limit.
package clock_pkg;
  localparam int MAX_MODULUS = 100;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD digit to active-low seven-segment code; non-BCD input blanks.
module seg7_decoder
  import clock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD up/down modulo counter with load and 7-seg outputs.
// Define LEADING_ZERO_BLANK_EN to blank HEX1 when the tens digit is zero.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS    = 60,
  parameter int INIT_VALUE = 0
) (
  input  logic       signal_clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       signal,
  output logic       load_err
);
  localparam logic [3:0] MAX_T  = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_O  = 4'((MODULUS - 1) % 10);
  localparam logic [3:0] INIT_T = 4'(INIT_VALUE / 10);
  localparam logic [3:0] INIT_O = 4'(INIT_VALUE % 10);
  logic [7:0] load_val;
  logic load_ok, at_max, at_zero;
  logic [3:0] up_t, up_o, dn_t, dn_o, hex1_digit;
  assign load_val = 8'(load_tens) * 8'd10 + 8'(load_ones);
  assign load_ok  = load_tens <= 4'd9 && load_ones <= 4'd9 && load_val < 8'(MODULUS);
  assign at_max   = tens == MAX_T && ones == MAX_O;
  assign at_zero  = tens == 4'd0 && ones == 4'd0;
  always_comb begin
    up_t = at_max ? 4'd0 : ones == 4'd9 ? tens + 4'd1 : tens;
    up_o = at_max ? 4'd0 : ones == 4'd9 ? 4'd0 : ones + 4'd1;
    dn_t = at_zero ? MAX_T : ones == 4'd0 ? tens - 4'd1 : tens;
    dn_o = at_zero ? MAX_O : ones == 4'd0 ? 4'd9 : ones - 4'd1;
  end
  always_ff @(posedge signal_clk) begin
    if (reset) begin
      tens     <= INIT_T;
      ones     <= INIT_O;
      signal   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      signal   <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) {tens, ones} <= {load_tens, load_ones};
        else load_err <= 1'b1;
      end else if (en) begin
        {tens, ones} <= up_down ? {up_t, up_o} : {dn_t, dn_o};
        signal       <= up_down ? at_max : at_zero;
      end
    end
  end
`ifdef LEADING_ZERO_BLANK_EN
  assign hex1_digit = tens == 4'd0 ? 4'hF : tens;
`else
  assign hex1_digit = tens;
`endif
  seg7_decoder u_hex1 (.digit(hex1_digit), .seg(HEX1));
  seg7_decoder u_hex0 (.digit(ones), .seg(HEX0));
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: directed vector table, randomized model check, cascade check.
module tb_bcd_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, en = 1'b0, up = 1'b0, ld = 1'b0;
  logic [3:0] lt = 4'd0, lo = 4'd0;
  logic [3:0] m_t, m_o, s_t, s_o, n_t, n_o, h_t, h_o;
  logic [6:0] m_h1, m_h0, s_h1, s_h0, n_h1, n_h0, h_h1, h_h0;
  logic m_sig, m_err, s_sig, s_err, n_sig, n_err, h_sig, h_err;
  logic c_rst = 1'b1, c_en = 1'b0;
  int pass_n = 0, total = 0;
  int v_main = 0, v_small = 3, e_msig = 0, e_merr = 0, e_ssig = 0, e_serr = 0;
  int segs[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  bcd_mod_counter #(.MODULUS(60), .INIT_VALUE(0)) u_main (
    .signal_clk(clk), .reset(rst), .en(en), .up_down(up), .load(ld), .load_tens(lt), .load_ones(lo),
    .tens(m_t), .ones(m_o), .HEX1(m_h1), .HEX0(m_h0), .signal(m_sig), .load_err(m_err));
  bcd_mod_counter #(.MODULUS(8), .INIT_VALUE(3)) u_small (
    .signal_clk(clk), .reset(rst), .en(en), .up_down(up), .load(ld), .load_tens(lt), .load_ones(lo),
    .tens(s_t), .ones(s_o), .HEX1(s_h1), .HEX0(s_h0), .signal(s_sig), .load_err(s_err));
  bcd_mod_counter #(.MODULUS(60), .INIT_VALUE(0)) u_min (
    .signal_clk(clk), .reset(c_rst), .en(c_en), .up_down(1'b1), .load(1'b0), .load_tens(4'd0), .load_ones(4'd0),
    .tens(n_t), .ones(n_o), .HEX1(n_h1), .HEX0(n_h0), .signal(n_sig), .load_err(n_err));
  bcd_mod_counter #(.MODULUS(24), .INIT_VALUE(23)) u_hr (
    .signal_clk(clk), .reset(c_rst), .en(n_sig), .up_down(1'b1), .load(1'b0), .load_tens(4'd0), .load_ones(4'd0),
    .tens(h_t), .ones(h_o), .HEX1(h_h1), .HEX0(h_h0), .signal(h_sig), .load_err(h_err));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_hex1(input int v);
`ifdef LEADING_ZERO_BLANK_EN
    return v / 10 == 0 ? 'h7F : segs[v / 10];
`else
    return segs[v / 10];
`endif
  endfunction

  // Behavioural reference: the count as a plain integer modulo m.
  task automatic model(input int m, input int init, inout int v, output int sig, output int err);
    int lv;
    lv = int'(lt) * 10 + int'(lo);
    sig = 0;
    err = 0;
    if (rst) v = init;
    else if (ld) begin
      if (lt <= 9 && lo <= 9 && lv < m) v = lv;
      else err = 1;
    end else if (en) begin
      v = up ? (v + 1) % m : (v + m - 1) % m;
      sig = up ? int'(v == 0) : int'(v == m - 1);
    end
  endtask

  task automatic check_dut(input string tag, input int v, input int sig, input int err,
                           input logic [3:0] t, input logic [3:0] o, input logic [6:0] h1,
                           input logic [6:0] h0, input logic s, input logic e);
    chk({tag, "_value"}, int'(t) * 10 + int'(o), v);
    chk({tag, "_signal"}, int'(s), sig);
    chk({tag, "_load_err"}, int'(e), err);
    chk({tag, "_hex1"}, int'(h1), exp_hex1(v));
    chk({tag, "_hex0"}, int'(h0), segs[v % 10]);
  endtask

  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [3:0] t, input logic [3:0] o);
    rst = r; en = e; up = u; ld = l; lt = t; lo = o;
    model(60, 0, v_main, e_msig, e_merr);
    model(8, 3, v_small, e_ssig, e_serr);
    @(posedge clk);
    #1;
    check_dut("small", v_small, e_ssig, e_serr, s_t, s_o, s_h1, s_h0, s_sig, s_err);
  endtask

  typedef struct {int rst, en, up, ld, lt, lo, val, sig, err;} vec_t;
  vec_t tbl[17];

  initial begin
    int changes, pulses, prev;
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 5, 8, 58, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0, 59, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 0, 0,  0, 1, 0};
    tbl[4]  = '{0, 1, 1, 0, 0, 0,  1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 59, 1, 0};
    tbl[7]  = '{0, 1, 1, 1, 7, 2, 59, 0, 1};
    tbl[8]  = '{0, 0, 1, 0, 0, 0, 59, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 4, 5, 45, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 3, 3, 33, 0, 0};
    tbl[11] = '{1, 1, 1, 1, 1, 0,  0, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 0, 0,  1, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 0, 5,  5, 0, 0};
    tbl[14] = '{0, 1, 0, 1, 6, 0,  5, 0, 1};
    tbl[15] = '{0, 1, 1, 1, 0, 10, 5, 0, 1};
    tbl[16] = '{0, 0, 1, 0, 0, 0,  5, 0, 0};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst != 0, tbl[i].en != 0, tbl[i].up != 0, tbl[i].ld != 0, 4'(tbl[i].lt), 4'(tbl[i].lo));
      check_dut($sformatf("vec%0d", i), tbl[i].val, tbl[i].sig, tbl[i].err,
                m_t, m_o, m_h1, m_h0, m_sig, m_err);
    end
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, 4'($urandom_range(0, 10)), 4'($urandom_range(0, 11)));
      check_dut("rand", v_main, e_msig, e_merr, m_t, m_o, m_h1, m_h0, m_sig, m_err);
    end
    // Cascade: minutes wrap at ticks 60 and 120, hours react one cycle later.
    @(posedge clk);
    #1;
    chk("cascade_reset_hours", int'(h_t) * 10 + int'(h_o), 23);
    chk("cascade_reset_minutes", int'(n_t) * 10 + int'(n_o), 0);
    c_rst = 1'b0;
    c_en = 1'b1;
    changes = 0;
    pulses = 0;
    prev = 23;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (int'(h_t) * 10 + int'(h_o) != prev) changes++;
      prev = int'(h_t) * 10 + int'(h_o);
      if (h_sig) pulses++;
    end
    chk("cascade_hour_changes", changes, 1);
    chk("cascade_hour_pulses", pulses, 1);
    chk("cascade_final_hours", prev, 0);
    chk("cascade_final_minutes", int'(n_t) * 10 + int'(n_o), 0);
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
